// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier sequencer: default width
// and the binary state encoding of the control FSM.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/mult_control_unit_iter_counter.sv
// Loadable down-counter with a zero flag; tracks the remaining multiplier bits.
module iter_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority over decrement.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mult_control_unit.sv
// Moore sequencer for the shift-and-add multiplier datapath: load, then one
// check/(add)/shift round per multiplier bit, then a one-cycle done pulse.
module mult_control_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       q0,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_cnt_zero;
  logic       w_cnt_load;
  logic       w_cnt_dec;

  // Host handshake: start is a request honoured only while busy=0; once taken,
  // busy stays high until the cycle after the single-cycle done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_CHECK;
      S_CHECK: w_next = q0 ? S_ADD : S_SHIFT;
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = w_cnt_zero ? S_DONE : S_CHECK;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The last SHIFT leaves the counter at zero, so it never wraps.
  assign w_cnt_load = (r_state == S_LOAD);
  assign w_cnt_dec  = (r_state == S_SHIFT) && !w_cnt_zero;

  iter_counter #(
    .W(CW)
  ) u_iter_counter (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (CNT_INIT),
    .o_zero     (w_cnt_zero)
  );

  assign load      = (r_state == S_LOAD);
  assign add       = (r_state == S_ADD);
  assign shift     = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE) && (r_state <= S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mult_control_unit.sv
// Bench for mult_control_unit: datapath model drives q0, an operation-level
// schedule model predicts every output cycle, plus directed latency literals.
module tb_mult_control_unit;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       q0;
  logic       load, add, shift, busy, done;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  logic [W-1:0] op_mult  = '0;
  logic [W-1:0] op_mcand = '0;
  logic [W:0]   dp_acc   = '0;
  logic [W-1:0] dp_m     = '0;

  // Expected outputs of the current and future cycles: {load,add,shift,done,busy}
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  assign q0 = dp_m[0];

  mult_control_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .q0        (q0),
    .load      (load),
    .add       (add),
    .shift     (shift),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One operation, cycle by cycle: LOAD, per bit CHECK [ADD] SHIFT, DONE.
  function automatic void push_op(input logic [W-1:0] m);
    exp_q.push_back(5'b10001);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(5'b00001);
      if (m[i]) exp_q.push_back(5'b01001);
      exp_q.push_back(5'b00101);
    end
    exp_q.push_back(5'b00011);
  endfunction

  // Datapath model: registers update on the strobes the sequencer issues.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      dp_acc = '0;
      dp_m   = op_mult;
    end else if (add === 1'b1) begin
      dp_acc = dp_acc + (W+1)'(op_mcand);
    end else if (shift === 1'b1) begin
      dp_m   = {dp_acc[0], dp_m[W-1:1]};
      dp_acc = dp_acc >> 1;
    end
  end

  // Per-cycle compare against the schedule model.
  always @(negedge clk) begin : cmp
    logic [4:0] e;
    bit         was_idle;
    if (armed) begin
      was_idle = (exp_q.size() == 0);
      e = was_idle ? 5'b00000 : exp_q.pop_front();
      chk("cycle_outputs", {27'b0, load, add, shift, done, busy}, {27'b0, e});
      chk("one_strobe", 32'($countones({load, add, shift, done}) <= 1), 32'd1);
      if (reset) exp_q.delete();
      else if (was_idle && start) push_op(op_mult);
    end
  end

  // Called at posedge+1 with the DUT idle; returns once the cycle after done begins.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] mc, input bit noise,
                        output int lat, output int n_add, output int n_shift,
                        output logic [2*W-1:0] prod, output logic [W-1:0] add_bits);
    int cyc;
    bit got;
    op_mult  = m;
    op_mcand = mc;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; n_add = 0; n_shift = 0; lat = -1; add_bits = '0; got = 1'b0; prod = '0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      if (add) begin
        if (n_shift < W) add_bits[n_shift] = 1'b1;
        n_add++;
      end
      if (shift) n_shift++;
      if (done) begin
        lat  = cyc;
        got  = 1'b1;
        prod = {dp_acc[W-1:0], dp_m};
      end
      @(posedge clk); #1;
      if (noise && busy && !done) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, na, ns, nd;
    logic [2*W-1:0] prod;
    logic [W-1:0] ab, m, mc;
    int done_cyc[3];
    int load_cyc[$];

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 armed = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_strobes", 32'({load, add, shift, done}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    run_op(8'h00, 8'h5A, 1'b0, lat, na, ns, prod, ab);
    chk("lat_00", lat, 18);
    chk("adds_00", na, 0);
    chk("shifts_00", ns, 8);
    chk("prod_00", prod, 0);
    chk("done_one_cycle", 32'(done), 32'd0);

    run_op(8'hFF, 8'h3C, 1'b0, lat, na, ns, prod, ab);
    chk("lat_ff", lat, 26);
    chk("adds_ff", na, 8);
    chk("prod_ff", prod, 32'h3BC4);

    run_op(8'hA5, 8'h3C, 1'b0, lat, na, ns, prod, ab);
    chk("lat_a5", lat, 22);
    chk("adds_a5", na, 4);
    chk("add_bits_a5", ab, 32'hA5);
    chk("prod_a5", prod, 32'h26AC);

    run_op(8'h5B, 8'h77, 1'b1, lat, na, ns, prod, ab);
    chk("lat_noise", lat, 23);
    chk("prod_noise", prod, 32'(16'h5B * 16'h77));

    // Reset while in ADD
    op_mult = 8'hFF; op_mcand = 8'h01; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nd = 0;
    while (!add && nd < 10) begin @(posedge clk); #1; nd++; end
    chk("reached_add", 32'(add), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_strobes", 32'({load, add, shift, done}), 32'd0);
    nd = 0;
    repeat (30) begin @(negedge clk); if (done) nd++; end
    chk("abort_no_done", nd, 0);
    @(posedge clk); #1;

    // start held high: back-to-back operations
    m = 8'($urandom); op_mult = m; op_mcand = 8'($urandom);
    start = 1'b1;
    nd = 0;
    load_cyc.delete();
    for (int c = 0; c < 200 && nd < 3; c++) begin
      @(negedge clk);
      if (load) load_cyc.push_back(c);
      if (done) begin done_cyc[nd] = c; nd++; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("held_dones", nd, 3);
    chk("held_loads", load_cyc.size(), 3);
    if (nd == 3 && load_cyc.size() == 3) begin
      for (int k = 0; k < 3; k++)
        chk("held_op_len", done_cyc[k] - load_cyc[k], 1 + 2*W + $countones(m));
      for (int k = 0; k < 2; k++)
        chk("held_restart", load_cyc[k+1] - done_cyc[k], 2);
    end
    repeat (3) begin @(posedge clk); #1; end

    // Randomized operations
    for (int t = 0; t < 25; t++) begin
      m  = 8'($urandom);
      mc = 8'($urandom);
      run_op(m, mc, 1'($urandom_range(0, 1)), lat, na, ns, prod, ab);
      chk("rand_lat", lat, 2 + 2*W + $countones(m));
      chk("rand_adds", na, $countones(m));
      chk("rand_shifts", ns, W);
      chk("rand_add_bits", ab, m);
      chk("rand_prod", prod, 32'(16'(m) * 16'(mc)));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
